// File: rtl/mem_arb_pkg.sv
// Shared definitions for the mem_arbiter block: FSM encoding, grant IDs and
// the legal read-latency range.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        DONE  = ST_DONE
    } arb_state_t;

    localparam logic GNT_INSTR = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic bit rd_lat_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-input grant picker (rr_arbiter2). Round-robin by default; defining
// MEM_ARBITER_FIXED_PRIO_EN makes the data port win every tie instead.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant,
    output logic any_req
);

    assign any_req = i_req | d_req;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = d_req ? GNT_DATA : GNT_INSTR;
    end
`else
    always_comb begin
        grant = GNT_INSTR;
        if (i_req && d_req) begin
            // Tie: the port that did not win last time goes first.
            grant = (last_grant == GNT_DATA) ? GNT_INSTR : GNT_DATA;
        end else if (d_req) begin
            grant = GNT_DATA;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port synchronous RAM between instruction fetch and data
// ports. Optional macro MEM_ARBITER_FIXED_PRIO_EN selects data-first priority.
//
// Handshake: a requester raises *_req with stable addr/we/wdata and holds it
// until it sees the one-cycle *_ack; in the cycle after ack it either drops
// req or presents the next request. Each access is IDLE->ISSUE->WAIT->DONE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [1:0]        state_dbg
);

    generate
        if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_check
            $error("mem_arbiter: RD_LAT must be within 1..4");
        end
    endgenerate

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    arb_state_t state, state_n;
    logic [1:0] cnt, cnt_n;
    logic       owner;
    logic       owner_we;
    logic       last_grant;
    logic       grant;
    logic       any_req;
    logic       load;
    logic       capture;

    rr_arbiter2 u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant      (grant),
        .any_req    (any_req)
    );

    assign state_dbg = state;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    load    = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                state_n = WAIT;
                cnt_n   = CNT_INIT;
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    capture = 1'b1;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - 2'd1;
                end
            end
            DONE: begin
                // Requester's req still reflects the finished access, so no grant here.
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            owner      <= GNT_INSTR;
            owner_we   <= 1'b0;
            last_grant <= GNT_DATA;
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            // m_en/m_we are only high in ISSUE: set on the grant edge, cleared on the next.
            m_en  <= load;
            m_we  <= load && (grant == GNT_DATA) && d_we;
            i_ack <= capture && (owner == GNT_INSTR);
            d_ack <= capture && (owner == GNT_DATA);
            if (load) begin
                owner      <= grant;
                owner_we   <= (grant == GNT_DATA) && d_we;
                last_grant <= grant;
                if (grant == GNT_DATA) begin
                    m_addr  <= d_addr;
                    m_wdata <= d_wdata;
                end else begin
                    m_addr  <= i_addr;
                end
            end
            if (capture && (owner == GNT_INSTR)) begin
                i_rdata <= m_rdata;
            end
            if (capture && (owner == GNT_DATA) && !owner_we) begin
                d_rdata <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed accesses, a scoreboard queue of
// expected {port, rdata} acks, and a second instance built with RD_LAT = 3.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;

    // RD_LAT = 1 instance
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic [1:0]    state_dbg;

    // RD_LAT = 3 instance
    logic          r3_i_req = 1'b0;
    logic [AW-1:0] r3_i_addr = '0;
    logic [DW-1:0] r3_i_rdata;
    logic          r3_i_ack;
    logic [DW-1:0] r3_d_rdata;
    logic          r3_d_ack;
    logic          r3_m_en;
    logic          r3_m_we;
    logic [AW-1:0] r3_m_addr;
    logic [DW-1:0] r3_m_wdata;
    logic [DW-1:0] r3_m_rdata;
    logic [1:0]    r3_state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard entries are {ack port (1 = data), rdata of that port}.
    logic [DW:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .state_dbg(state_dbg)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .i_req(r3_i_req), .i_addr(r3_i_addr), .i_rdata(r3_i_rdata), .i_ack(r3_i_ack),
        .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
        .d_rdata(r3_d_rdata), .d_ack(r3_d_ack),
        .m_en(r3_m_en), .m_we(r3_m_we), .m_addr(r3_m_addr), .m_wdata(r3_m_wdata),
        .m_rdata(r3_m_rdata), .state_dbg(r3_state_dbg)
    );

    // ---------------- memory model ----------------
    // Read data is only valid for exactly the cycle(s) the latency allows;
    // otherwise the read bus shows a poison value.
    logic [DW-1:0] mem [0:255];
    logic          pre_we = 1'b0;
    logic [7:0]    pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    logic [DW-1:0] rd1;
    logic [DW-1:0] r3_p0, r3_p1, r3_p2;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (m_en && m_we) mem[m_addr[7:0]] <= m_wdata;
        rd1   <= (m_en && !m_we) ? mem[m_addr[7:0]] : 16'hDEAD;
        r3_p0 <= (r3_m_en && !r3_m_we) ? mem[r3_m_addr[7:0]] : 16'hDEAD;
        r3_p1 <= r3_p0;
        r3_p2 <= r3_p1;
    end
    assign m_rdata    = rd1;
    assign r3_m_rdata = r3_p2;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (i_ack || d_ack) begin
            logic [DW:0] got, e;
            n_cmp++;
            got = d_ack ? {1'b1, d_rdata} : {1'b0, i_rdata};
            if (i_ack && d_ack) begin
                n_fail++;
                $display("FAIL ack_excl: i_ack=%0b d_ack=%0b, required only one", i_ack, d_ack);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ack_unexpected: got port=%0b data=%h, required no ack", got[DW], got[DW-1:0]);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL ack_data: got port=%0b data=%h, required port=%0b data=%h",
                             got[DW], got[DW-1:0], e[DW], e[DW-1:0]);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        tick();
        pre_we = 1'b0;
    endtask

    // Counts cycles from the current one until either ack appears.
    task automatic wait_ack(input string name, input int max_cyc, output int cyc,
                            output int en_cnt, output int we_cnt, output logic [AW-1:0] addr_seen);
        cyc = 0; en_cnt = 0; we_cnt = 0; addr_seen = '1;
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            if (m_en) begin
                en_cnt++;
                addr_seen = m_addr;
            end
            if (m_we) we_cnt++;
            if (i_ack || d_ack) begin
                cyc = c;
                break;
            end
        end
        if (cyc == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: no ack within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic do_single(input string name, input bit port, input bit we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic [DW:0] exp);
        int cyc, en_cnt, we_cnt;
        logic [AW-1:0] a_seen;
        exp_q.push_back(exp);
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        wait_ack(name, 20, cyc, en_cnt, we_cnt, a_seen);
        check({name, "_latency"}, 64'(cyc), 64'd3);
        check({name, "_m_en_cycles"}, 64'(en_cnt), 64'd1);
        check({name, "_m_we_cycles"}, 64'(we_cnt), 64'(we));
        check({name, "_m_addr"}, 64'(a_seen), 64'(addr));
        tick();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, en_cnt, we_cnt;
        logic [AW-1:0] a_seen;
        logic          first_port;

        reset = 1'b0;
        preload(8'h10, 16'hBEEF);
        preload(8'h20, 16'hA5A5);
        preload(8'h30, 16'h5A5A);
        preload(8'h40, 16'hC0DE);
        tick();
        check("reset_state", 64'(state_dbg), 64'(0));
        check("reset_outputs", {m_en, m_we, i_ack, d_ack, m_addr, m_wdata, i_rdata, d_rdata}, 64'd0);
        reset = 1'b1;
        tick();

        // Fetch only
        do_single("fetch", 1'b0, 1'b0, 16'h0010, 16'h0000, {1'b0, 16'hBEEF});
        tick();

        // Data write then read back; a write leaves d_rdata at its reset value
        do_single("write", 1'b1, 1'b1, 16'h0100, 16'h1234, {1'b1, 16'h0000});
        tick();
        check("write_landed", 64'(mem[8'h00]), 64'h1234);
        do_single("read", 1'b1, 1'b0, 16'h0100, 16'h0000, {1'b1, 16'h1234});
        tick();

        // Contention from reset release: both requests held high
        reset = 1'b0;
        tick();
        i_req = 1'b1; i_addr = 16'h0020;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        first_port = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 16'h5A5A});
`else
        first_port = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b0, 16'hA5A5});
            exp_q.push_back({1'b1, 16'h5A5A});
        end
`endif
        exp_q.push_back({1'b0, 16'hA5A5});
        reset = 1'b1;
        wait_ack("cont0", 20, cyc, en_cnt, we_cnt, a_seen);
        check("cont_first_latency", 64'(cyc), 64'd3);
        check("cont_first_port", 64'(d_ack), 64'(first_port));
        for (int k = 1; k < 4; k++) begin
            wait_ack("cont", 20, cyc, en_cnt, we_cnt, a_seen);
            check("cont_ack_spacing", 64'(cyc), 64'd4);
        end
        tick();
        d_req = 1'b0;
        wait_ack("cont_last", 20, cyc, en_cnt, we_cnt, a_seen);
        check("cont_instr_after_drop", 64'(cyc), 64'd3);
        tick();
        i_req = 1'b0;
        tick();

        // Back-to-back fetches: new address presented the cycle after ack
        exp_q.push_back({1'b0, 16'hBEEF});
        exp_q.push_back({1'b0, 16'hC0DE});
        i_req = 1'b1; i_addr = 16'h0010;
        wait_ack("b2b0", 20, cyc, en_cnt, we_cnt, a_seen);
        check("b2b_first_latency", 64'(cyc), 64'd3);
        tick();
        i_addr = 16'h0040;
        check("b2b_no_dup_ack", 64'(i_ack), 64'd0);
        wait_ack("b2b1", 20, cyc, en_cnt, we_cnt, a_seen);
        check("b2b_second_latency", 64'(cyc), 64'd3);
        check("b2b_second_addr", 64'(a_seen), 64'h0040);
        tick();
        i_req = 1'b0;
        tick();

        // Reset during WAIT abandons the access without an ack
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
        tick();
        tick();
        check("midrst_in_wait", 64'(state_dbg), 64'(2));
        reset = 1'b0; d_req = 1'b0;
        tick();
        check("midrst_state", 64'(state_dbg), 64'(0));
        check("midrst_outputs", {m_en, m_we, i_ack, d_ack, m_addr, m_wdata, i_rdata, d_rdata}, 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        do_single("post_rst_read", 1'b1, 1'b0, 16'h0100, 16'h0000, {1'b1, 16'h1234});
        tick();

        // RD_LAT = 3 instance: single fetch
        cyc = 0; en_cnt = 0;
        r3_i_req = 1'b1; r3_i_addr = 16'h0010;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (r3_m_en) en_cnt++;
            if (r3_i_ack || r3_d_ack) begin
                cyc = c;
                check("lat3_rdata", 64'(r3_i_rdata), 64'hBEEF);
                check("lat3_dack", 64'(r3_d_ack), 64'd0);
                break;
            end
        end
        check("lat3_latency", 64'(cyc), 64'd5);
        check("lat3_m_en_cycles", 64'(en_cnt), 64'd1);
        tick();
        r3_i_req = 1'b0;
        tick();
        tick();

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between the CPU instruction-fetch port and the CPU data port, giving the unified instruction/data memory map a real arbitrated memory.
- Sits between the cpu instance (instr/instr_addr, data_addr/data_in/data_out/we_dmem through thin req/ack adapters) and the RAM macro.
- Serialises accesses with a req/ack handshake and a fair grant policy.

Parameters:
- ADDR_W, 16, address width of both requesters and memory.
- DATA_W, 16, data width.
- RD_LAT, 1, memory read latency in cycles (legal range 1..4); sets the WAIT state length.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous reset, active-low (asserted while 0, sampled on the rising edge of clk).
- i_req  input  1  instruction fetch request; held until i_ack.
- i_addr  input  ADDR_W  fetch address; stable while i_req is high.
- i_rdata  output  DATA_W  fetched word; valid while i_ack is high.
- i_ack  output  1  one-cycle completion pulse for the fetch.
- d_req  input  1  data request; held until d_ack.
- d_we  input  1  1 = write, 0 = read; stable with d_req.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_rdata  output  DATA_W  read data; valid while d_ack is high.
- d_ack  output  1  one-cycle completion pulse for the data access.
- m_en  output  1  memory enable (registered).
- m_we  output  1  memory write enable (registered).
- m_addr  output  ADDR_W  memory address (registered).
- m_wdata  output  DATA_W  memory write data (registered).
- m_rdata  input  DATA_W  memory read data; valid RD_LAT cycles after the edge that samples m_en.

Behaviour:
- Reset values:
  - state = IDLE.
  - m_en, m_we, i_ack and d_ack = 0.
  - m_addr, m_wdata, i_rdata and d_rdata = 0.
  - last_grant = DATA, so the first tie goes to the instruction port.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick a winner, latch owner, address, we and wdata into the m_* registers with m_en = 1, then go to ISSUE.
- ISSUE:
  - m_en and m_we are driven for exactly this one cycle; the memory samples at its end.
  - Next state is WAIT, with the wait counter loaded to RD_LAT-1.
- WAIT:
  - m_en = 0 and m_we = 0.
  - Lasts RD_LAT cycles.
  - On the final cycle, capture m_rdata into the owner's rdata register (reads only) and go to DONE.
- DONE:
  - Owner's ack = 1 for this single cycle; the other ack stays 0.
  - Next state is always IDLE.
  - No arbitration in DONE, because the requester's req is still the old one.
- Latency (RD_LAT = 1):
  - req seen in IDLE at cycle 0.
  - ISSUE at cycle 1, WAIT at cycle 2.
  - ack plus data at cycle 3.
  - Peak throughput is 1 access per RD_LAT+3 cycles.
- Handshake rules:
  - A requester keeps req, addr, we and wdata stable until it samples ack.
  - In the cycle after ack it either drops req or presents a new request.
- Writes: d_ack follows the same timing as a read; d_rdata holds its previous value.
- rdata registers hold their value until the owner's next read completes.
- Arbitration (default): round-robin.
  - Only one requester active: it wins.
  - Both active: the port not equal to last_grant wins.
  - last_grant updates on each IDLE grant.
- Simultaneous events:
  - A request that arrives while busy waits in IDLE order; it is never dropped.
  - A losing requester is granted on the next IDLE entry.
- Reset mid-operation:
  - The FSM returns to IDLE and all outputs take their reset values.
  - The in-flight access is abandoned with no ack.
  - A write whose ISSUE edge has already passed may have reached the memory; this is acceptable.
- Address wrap: no arithmetic is performed on addresses; they pass through unchanged.

Optional Feature:
- MEM_ARBITER_FIXED_PRIO_EN defined: fixed priority. When both requesters are active the data port always wins; last_grant is ignored.
- Not defined: round-robin as described above.
- Timing and the handshake are identical in both modes.

Decomposition:
- mem_arb_pkg:
  - State encoding localparams (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3).
  - Grant IDs GNT_INSTR = 1'b0, GNT_DATA = 1'b1.
  - RD_LAT range-check constant.
- Sub-module rr_arbiter2: 2-input picker with last_grant input and grant output, and the fixed-priority option inside it. The FSM and datapath stay in mem_arbiter.

Test Plan:
- Fetch only: mem[0x0010] = 0xBEEF, i_req with i_addr = 0x0010 at cycle 0 -> m_en = 1 with m_addr = 0x0010 in cycle 1; i_ack = 1 with i_rdata = 0xBEEF in cycle 3; d_ack stays 0.
- Data write then read: d_we = 1, d_addr = 0x0100, d_wdata = 0x1234 -> m_we = 1 for exactly 1 cycle, then d_ack. Then a read of 0x0100 -> d_rdata = 0x1234.
- Contention: i_req and d_req both asserted from reset release, held high -> grants go I, D, I, D; acks are 4 cycles apart.
  - With MEM_ARBITER_FIXED_PRIO_EN: D is granted first, and I is granted only after d_req drops.
- RD_LAT = 3: a single read -> ack arrives at cycle 5; m_en is high for only 1 cycle.
- Reset mid-access: reset = 0 during WAIT -> next cycle state = IDLE, all outputs 0, no ack. A subsequent request is serviced normally.
- Back-to-back: requester re-asserts i_req with a new address the cycle after i_ack -> second access starts at that IDLE cycle; no duplicate ack for the first address.
